// File: rtl/bus_arbiter_if.sv
// Request/grant bundle between the two bus masters and the arbiter.
// master drives requests; slave is the arbiter side.
interface bus_arbiter_if;
  logic m0_req;
  logic m1_req;
  logic m0_grant;
  logic m1_grant;
  logic m_sel;
  logic bus_busy;

  modport master (
    output m0_req,
    output m1_req,
    input  m0_grant,
    input  m1_grant,
    input  m_sel,
    input  bus_busy
  );

  modport slave (
    input  m0_req,
    input  m1_req,
    output m0_grant,
    output m1_grant,
    output m_sel,
    output bus_busy
  );
endinterface

// File: rtl/bus_arbiter.sv
// Two-master bus arbiter, parked on master 0, with a contention
// hold limit that forces hand-over so neither master starves.
module bus_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  bus_arbiter_if.slave  bus
);

  typedef enum logic {
    M0_GRANT = 1'b0,
    M1_GRANT = 1'b1
  } state_t;

  localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] hold_cnt;
  logic [3:0] hold_nxt;
  logic       contended;
  logic       at_limit;

  // Both requesting means the owner is contended, whoever owns it.
  assign contended = bus.m0_req & bus.m1_req;
  assign at_limit  = (hold_cnt == HOLD_LAST);

  always_comb begin
    state_nxt = state;
    hold_nxt  = 4'd0;
    unique case (state)
      M0_GRANT: begin
        if (!bus.m0_req && bus.m1_req)
          state_nxt = M1_GRANT;
        else if (contended && at_limit)
          state_nxt = M1_GRANT;
      end
      M1_GRANT: begin
        if (!bus.m1_req)
          state_nxt = M0_GRANT;
        else if (contended && at_limit)
          state_nxt = M0_GRANT;
      end
    endcase
    if (state_nxt == state && contended)
      hold_nxt = hold_cnt + 4'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= M0_GRANT;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  assign bus.m0_grant = (state == M0_GRANT);
  assign bus.m1_grant = (state == M1_GRANT);
  assign bus.m_sel    = (state == M1_GRANT);
  assign bus.bus_busy =
    ((state == M0_GRANT) & bus.m0_req) |
    ((state == M1_GRANT) & bus.m1_req);

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed plus random checks of bus_arbiter against an
// owner/contention-run reference model.
module tb_bus_arbiter;

  localparam int MAX_HOLD = 8;

  logic clk = 1'b0;
  logic reset_n;

  bus_arbiter_if bus ();

  bus_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model: current owner and contended cycles this tenure
  int owner = 0;
  int run   = 0;
  int wait0 = 0;
  int wait1 = 0;
  int cnt0  = 0;
  int cnt1  = 0;

  task automatic chk(input string tag, input logic obs,
                     input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic r0, input logic r1);
    logic rq [2];
    int   other;
    rq[0] = r0;
    rq[1] = r1;
    other = 1 - owner;
    if (!rq[owner]) begin
      owner = (owner == 0 && rq[1]) ? 1 : 0;
      run   = 0;
    end else if (rq[other]) begin
      run++;
      if (run == MAX_HOLD) begin
        owner = other;
        run   = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  task automatic chk_all();
    logic exp_busy;
    exp_busy = (owner == 0) ? bus.m0_req : bus.m1_req;
    chk("m0_grant", bus.m0_grant, logic'(owner == 0));
    chk("m1_grant", bus.m1_grant, logic'(owner == 1));
    chk("m_sel",    bus.m_sel,    logic'(owner == 1));
    chk("bus_busy", bus.bus_busy, exp_busy);
    chk("one_hot",  bus.m0_grant ^ bus.m1_grant, 1'b1);
    if (bus.m0_req && !bus.m0_grant) wait0++;
    else wait0 = 0;
    if (bus.m1_req && !bus.m1_grant) wait1++;
    else wait1 = 0;
    chk("wait0_bound", logic'(wait0 <= MAX_HOLD), 1'b1);
    chk("wait1_bound", logic'(wait1 <= MAX_HOLD), 1'b1);
  endtask

  // inputs change at negedge; edge applied; outputs sampled at negedge
  task automatic step(input logic r0, input logic r1);
    bus.m0_req = r0;
    bus.m1_req = r1;
    @(posedge clk);
    model_edge(r0, r1);
    @(negedge clk);
    chk_all();
  endtask

  initial begin
    reset_n    = 1'b0;
    bus.m0_req = 1'b0;
    bus.m1_req = 1'b0;
    @(negedge clk);
    chk("rst_m0_grant", bus.m0_grant, 1'b1);
    chk("rst_m1_grant", bus.m1_grant, 1'b0);
    chk("rst_m_sel",    bus.m_sel,    1'b0);
    chk("rst_bus_busy", bus.bus_busy, 1'b0);
    reset_n = 1'b1;

    // idle parking
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0);

    // lone m1 request and release
    step(1'b0, 1'b1);
    chk("m1_alone_grant", bus.m1_grant, 1'b1);
    chk("m1_alone_sel",   bus.m_sel,    1'b1);
    step(1'b0, 1'b0);
    chk("m1_release", bus.m0_grant, 1'b1);

    // continuous contention: strict alternation
    cnt0 = 0;
    cnt1 = 0;
    for (int i = 0; i < 64; i++) begin
      step(1'b1, 1'b1);
      if (bus.m0_grant) cnt0++;
      if (bus.m1_grant) cnt1++;
    end
    chk("share_m0_32", logic'(cnt0 == 32), 1'b1);
    chk("share_m1_32", logic'(cnt1 == 32), 1'b1);
    step(1'b0, 1'b0);

    // a gap in contention restarts the hold window
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1);
    step(1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b1);
    chk("fresh_hold_m0", bus.m0_grant, 1'b1);
    step(1'b1, 1'b1);
    chk("forced_m1", bus.m1_grant, 1'b1);
    step(1'b0, 1'b0);

    // asynchronous reset while m1 owns the bus
    step(1'b0, 1'b1);
    chk("pre_rst_m1", bus.m1_grant, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("async_m0_grant", bus.m0_grant, 1'b1);
    chk("async_m1_grant", bus.m1_grant, 1'b0);
    chk("async_m_sel",    bus.m_sel,    1'b0);
    owner = 0;
    run   = 0;
    wait0 = 0;
    wait1 = 0;
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 1'b1);
    chk("post_rst_m1", bus.m1_grant, 1'b1);

    // biased random streams for long contention runs
    for (int i = 0; i < 10000; i++)
      step(logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 3) != 0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
